// File: rtl/debug_dump_tx.sv
// debug_dump_tx: serialises PC, register file and data memory to the host as 8N1 UART bytes after a halt.
module debug_dump_tx #(
    parameter int NB_DATA      = 32,
    parameter int NB_REG       = 5,
    parameter int NB_ADDR      = 7,
    parameter int N_REGISTER   = 32,
    parameter int N_MEM_WORDS  = 32,
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_i,
    input  logic [NB_ADDR-1:0] pc_i,
    input  logic [NB_DATA-1:0] reg_data_i,
    input  logic [NB_DATA-1:0] mem_data_i,
    output logic               sel_reg_o,
    output logic [NB_REG-1:0]  addr_reg_o,
    output logic               sel_mem_o,
    output logic [NB_ADDR-1:0] addr_mem_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               tx_o
);
    localparam int N_WORDS = 1 + N_REGISTER + N_MEM_WORDS;
    localparam int NB_W    = $clog2(N_WORDS);
    localparam int NB_BAUD = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NB_BYTE = $clog2(NB_DATA / 8);

    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, TX_START, TX_DATA, TX_STOP, DONE} state_t;

    state_t              state_q;
    logic [NB_W-1:0]     word_q;
    logic [NB_W-1:0]     word_d;
    logic [NB_W-1:0]     mem_idx;
    logic [NB_BAUD-1:0]  baud_q;
    logic [2:0]          bit_q;
    logic [NB_BYTE-1:0]  byte_q;
    logic [NB_DATA-1:0]  shift_q;
    logic [7:0]          cur_byte;
    logic                baud_end;
    logic                is_reg_d;
    logic                is_mem_d;
    logic [NB_REG-1:0]   addr_reg_d;
    logic [NB_ADDR-1:0]  addr_mem_d;

    // Word that the next ADDR state will present; IDLE always restarts from the PC word.
    assign word_d     = (state_q == IDLE) ? '0 : word_q + 1'b1;
    assign is_reg_d   = (word_d != '0) && (word_d <= NB_W'(N_REGISTER));
    assign is_mem_d   = word_d > NB_W'(N_REGISTER);
    assign mem_idx    = word_d - NB_W'(N_REGISTER + 1);
    assign addr_reg_d = is_reg_d ? NB_REG'(word_d - 1'b1) : '0;
    assign addr_mem_d = is_mem_d ? NB_ADDR'({mem_idx, 2'b00}) : '0;
    assign cur_byte   = shift_q[NB_DATA-1 -: 8];
    assign baud_end   = baud_q == NB_BAUD'(CLKS_PER_BIT - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            sel_reg_o  <= 1'b0;
            addr_reg_o <= '0;
            sel_mem_o  <= 1'b0;
            addr_mem_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            tx_o       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q    <= ADDR;
                    busy_o     <= 1'b1;
                    word_q     <= word_d;
                    sel_reg_o  <= is_reg_d;
                    addr_reg_o <= addr_reg_d;
                    sel_mem_o  <= is_mem_d;
                    addr_mem_o <= addr_mem_d;
                end
                ADDR: state_q <= CAPTURE;
                CAPTURE: begin
                    shift_q <= (word_q == '0) ? NB_DATA'(pc_i) : sel_reg_o ? reg_data_i : mem_data_i;
                    byte_q  <= '0;
                    baud_q  <= '0;
                    tx_o    <= 1'b0;
                    state_q <= TX_START;
                end
                TX_START: if (baud_end) begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_o    <= cur_byte[0];
                    state_q <= TX_DATA;
                end else baud_q <= baud_q + 1'b1;
                TX_DATA: if (baud_end) begin
                    baud_q <= '0;
                    if (bit_q == 3'd7) begin
                        tx_o    <= 1'b1;
                        state_q <= TX_STOP;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_o  <= cur_byte[bit_q + 3'd1];
                    end
                end else baud_q <= baud_q + 1'b1;
                TX_STOP: if (baud_end) begin
                    baud_q <= '0;
                    if (byte_q != NB_BYTE'(NB_DATA / 8 - 1)) begin
                        byte_q  <= byte_q + 1'b1;
                        shift_q <= shift_q << 8;
                        tx_o    <= 1'b0;
                        state_q <= TX_START;
                    end else if (word_q == NB_W'(N_WORDS - 1)) begin
                        state_q    <= DONE;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        sel_reg_o  <= 1'b0;
                        addr_reg_o <= '0;
                        sel_mem_o  <= 1'b0;
                        addr_mem_o <= '0;
                    end else begin
                        word_q     <= word_d;
                        sel_reg_o  <= is_reg_d;
                        addr_reg_o <= addr_reg_d;
                        sel_mem_o  <= is_mem_d;
                        addr_mem_o <= addr_mem_d;
                        state_q    <= ADDR;
                    end
                end else baud_q <= baud_q + 1'b1;
                DONE: begin
                    done_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
